// File: rtl/fir_pkg.sv
// Shared constants for the filter capture path: sample width, capture FSM
// encoding and two's-complement limits used to seed the peak trackers.
package fir_pkg;

  localparam int SAMPLE_W = 16;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE    = 2'd0;
  localparam state_t ST_SKIP    = 2'd1;
  localparam state_t ST_CAPTURE = 2'd2;
  localparam state_t ST_READOUT = 2'd3;

  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MAX = 16'sh7FFF;
  localparam logic signed [SAMPLE_W-1:0] SAMPLE_MIN = 16'sh8000;

  // Counter width that stays at least one bit for degenerate sizes.
  function automatic int clog2_min1(input int v);
    return (v < 2) ? 1 : $clog2(v);
  endfunction

endpackage

// File: rtl/capture_ram.sv
// Capture buffer: one write port, one synchronous read port with a
// single cycle of read latency. Contents are never reset.
module capture_ram
  import fir_pkg::*;
#(
  parameter int N     = SAMPLE_W,
  parameter int DEPTH = 32,
  parameter int AW    = clog2_min1(DEPTH)
) (
  input  logic          clk_i,
  input  logic          we_i,
  input  logic [AW-1:0] waddr_i,
  input  logic [N-1:0]  wdata_i,
  input  logic [AW-1:0] raddr_i,
  output logic [N-1:0]  rdata_o
);

  logic [N-1:0] mem_q [DEPTH];

  always_ff @(posedge clk_i) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
    rdata_o <= mem_q[raddr_i];
  end

endmodule

// File: rtl/sample_capture.sv
// Arms on request, discards the filter fill samples, captures DEPTH samples
// with signed peak tracking, then streams them out over a valid/ready port.
module sample_capture
  import fir_pkg::*;
#(
  parameter int N     = SAMPLE_W,
  parameter int DEPTH = 32,
  parameter int SKIP  = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                arm,
  input  logic [N-1:0]        sample_in,
  input  logic                sample_valid,
  output logic                busy,
  output logic                done,
  output logic [N-1:0]        rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                rd_last,
  output logic signed [N-1:0] peak_max,
  output logic signed [N-1:0] peak_min
);

  localparam int AW  = clog2_min1(DEPTH);
  localparam int SKW = clog2_min1(SKIP + 1);

  localparam logic [AW-1:0]  WR_LAST   = AW'(DEPTH - 1);
  localparam logic [SKW-1:0] SKIP_LAST = SKW'((SKIP > 0) ? SKIP - 1 : 0);

  localparam logic signed [N-1:0] S_MAX = {1'b0, {(N-1){1'b1}}};
  localparam logic signed [N-1:0] S_MIN = {1'b1, {(N-1){1'b0}}};

  state_t                state_q, state_d;
  logic [SKW-1:0]        skip_q, skip_d;
  logic [AW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]         rd_idx_q, rd_idx_d;
  logic                  rd_valid_q, rd_valid_d;
  logic                  done_q, done_d;
  logic signed [N-1:0]   peak_max_q, peak_max_d;
  logic signed [N-1:0]   peak_min_q, peak_min_d;

  logic signed [N-1:0]   sample_s;
  logic                  wr_en;
  logic                  rd_fire;
  logic [AW-1:0]         rd_addr;
  logic [N-1:0]          ram_rdata;

  assign sample_s = sample_in;
  assign rd_fire  = rd_valid_q && rd_ready;

  // Present the next index on a handshake so the RAM latency is hidden and
  // words stream without bubbles; during a stall the same word is re-read.
  assign rd_addr = rd_fire ? (rd_idx_q + 1'b1) : rd_idx_q;

  always_comb begin
    state_d    = state_q;
    skip_d     = skip_q;
    wr_ptr_d   = wr_ptr_q;
    rd_idx_d   = rd_idx_q;
    rd_valid_d = rd_valid_q;
    done_d     = 1'b0;
    peak_max_d = peak_max_q;
    peak_min_d = peak_min_q;
    wr_en      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (arm) begin
          skip_d     = '0;
          wr_ptr_d   = '0;
          rd_idx_d   = '0;
          peak_max_d = S_MIN;
          peak_min_d = S_MAX;
          state_d    = (SKIP == 0) ? ST_CAPTURE : ST_SKIP;
        end
      end

      ST_SKIP: begin
        if (sample_valid) begin
          skip_d = skip_q + 1'b1;
          if (skip_q == SKIP_LAST) begin
            state_d = ST_CAPTURE;
          end
        end
      end

      ST_CAPTURE: begin
        if (sample_valid) begin
          wr_en    = 1'b1;
          wr_ptr_d = wr_ptr_q + 1'b1;
          if (sample_s > peak_max_q) begin
            peak_max_d = sample_s;
          end
          if (sample_s < peak_min_q) begin
            peak_min_d = sample_s;
          end
          if (wr_ptr_q == WR_LAST) begin
            state_d = ST_READOUT;
            done_d  = 1'b1;
          end
        end
      end

      ST_READOUT: begin
        // First cycle here only waits for word 0 to come out of the RAM.
        if (!rd_valid_q) begin
          rd_valid_d = 1'b1;
        end else if (rd_fire) begin
          rd_idx_d = rd_idx_q + 1'b1;
          if (rd_idx_q == WR_LAST) begin
            rd_valid_d = 1'b0;
            state_d    = ST_IDLE;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      skip_q     <= '0;
      wr_ptr_q   <= '0;
      rd_idx_q   <= '0;
      rd_valid_q <= 1'b0;
      done_q     <= 1'b0;
      peak_max_q <= S_MIN;
      peak_min_q <= S_MAX;
    end else begin
      state_q    <= state_d;
      skip_q     <= skip_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_idx_q   <= rd_idx_d;
      rd_valid_q <= rd_valid_d;
      done_q     <= done_d;
      peak_max_q <= peak_max_d;
      peak_min_q <= peak_min_d;
    end
  end

  capture_ram #(
    .N     (N),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk_i   (clk),
    .we_i    (wr_en),
    .waddr_i (wr_ptr_q),
    .wdata_i (sample_in),
    .raddr_i (rd_addr),
    .rdata_o (ram_rdata)
  );

  assign busy     = (state_q != ST_IDLE);
  assign done     = done_q;
  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_valid_q ? ram_rdata : '0;
  assign rd_last  = rd_valid_q && (rd_idx_q == WR_LAST);
  assign peak_max = peak_max_q;
  assign peak_min = peak_min_q;

endmodule

// File: tb/tb_sample_capture.sv
// Bench for sample_capture: a SKIP=8 and a SKIP=0 instance share stimulus and
// are compared every cycle against a sample-list model of a capture session.
module tb_sample_capture;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        arm = 1'b0;
  logic        sample_valid = 1'b0;
  logic        rd_ready = 1'b0;
  logic [15:0] sample_in = '0;

  logic        busy_w [2];
  logic        done_w [2];
  logic        rdv_w  [2];
  logic        rdl_w  [2];
  logic [15:0] rdd_w  [2];
  logic [15:0] pmx_w  [2];
  logic [15:0] pmn_w  [2];

  always #5 clk = ~clk;

  sample_capture #(.N(16), .DEPTH(DEPTH), .SKIP(8)) dut (
    .clk(clk), .reset(reset), .arm(arm), .sample_in(sample_in),
    .sample_valid(sample_valid), .busy(busy_w[0]), .done(done_w[0]),
    .rd_data(rdd_w[0]), .rd_valid(rdv_w[0]), .rd_ready(rd_ready),
    .rd_last(rdl_w[0]), .peak_max(pmx_w[0]), .peak_min(pmn_w[0])
  );

  sample_capture #(.N(16), .DEPTH(DEPTH), .SKIP(0)) dut0 (
    .clk(clk), .reset(reset), .arm(arm), .sample_in(sample_in),
    .sample_valid(sample_valid), .busy(busy_w[1]), .done(done_w[1]),
    .rd_data(rdd_w[1]), .rd_valid(rdv_w[1]), .rd_ready(rd_ready),
    .rd_last(rdl_w[1]), .peak_max(pmx_w[1]), .peak_min(pmn_w[1])
  );

  int n_chk = 0;
  int n_pass = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  function automatic int skv(input int k);
    return (k == 0) ? 8 : 0;
  endfunction

  // Session model: 0 idle, 1 collecting (skip + capture), 2 reading out.
  int                 mode [2];
  int                 skp  [2];
  int                 wcnt [2];
  int                 rcnt [2];
  int                 age  [2];
  logic signed [15:0] pmax [2];
  logic signed [15:0] pmin [2];
  logic signed [15:0] mbuf [2][DEPTH];
  logic               rdv_e [2];
  bit                 en = 1'b0;

  // Model state at each negedge describes the DUT after the last posedge;
  // inputs at this point are the ones the next posedge will sample.
  always @(negedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (age[k] >= 0 && age[k] < 3) age[k]++;
      rdv_e[k] = (mode[k] == 2) && (age[k] >= 2);
      if (en) begin
        check_eq($sformatf("busy%0d", k), busy_w[k], mode[k] != 0);
        check_eq($sformatf("done%0d", k), done_w[k], age[k] == 1);
        check_eq($sformatf("rd_valid%0d", k), rdv_w[k], rdv_e[k]);
        check_eq($sformatf("rd_last%0d", k), rdl_w[k], rdv_e[k] && (rcnt[k] == DEPTH - 1));
        if (rdv_e[k])
          check_eq($sformatf("rd_data%0d_w%0d", k, rcnt[k]), rdd_w[k], $unsigned(mbuf[k][rcnt[k]]));
        check_eq($sformatf("peak_max%0d", k), pmx_w[k], $unsigned(pmax[k]));
        check_eq($sformatf("peak_min%0d", k), pmn_w[k], $unsigned(pmin[k]));
      end
      if (reset) begin
        mode[k] = 0; skp[k] = 0; wcnt[k] = 0; rcnt[k] = 0; age[k] = -1;
        pmax[k] = 16'sh8000; pmin[k] = 16'sh7FFF;
      end else begin
        case (mode[k])
          0: if (arm) begin
            mode[k] = 1; skp[k] = 0; wcnt[k] = 0; rcnt[k] = 0; age[k] = -1;
            pmax[k] = 16'sh8000; pmin[k] = 16'sh7FFF;
          end
          1: if (sample_valid) begin
            if (skp[k] < skv(k)) skp[k]++;
            else begin
              mbuf[k][wcnt[k]] = sample_in;
              wcnt[k]++;
              if ($signed(sample_in) > pmax[k]) pmax[k] = sample_in;
              if ($signed(sample_in) < pmin[k]) pmin[k] = sample_in;
              if (wcnt[k] == DEPTH) begin mode[k] = 2; age[k] = 0; end
            end
          end
          default: if (rdv_e[k] && rd_ready) begin
            rcnt[k]++;
            if (rcnt[k] == DEPTH) begin mode[k] = 0; age[k] = -1; end
          end
        endcase
      end
    end
    if (reset) en = 1'b1;
  end

  function automatic logic [15:0] sine(input int i);
    real r;
    r = 16320.0 * $sin(2.0 * 3.14159265358979 * i / 32.0);
    return 16'($rtoi(r + ((r >= 0.0) ? 0.5 : -0.5)));
  endfunction

  // kind: 1 ramp, 2 sine with toggling valid, 3 random with stall on word 5,
  // 4 random with arm mid-capture, 5 reset at write 12, 6 all -1, 7 random.
  task automatic run(input int kind);
    int idx = 0;
    int stalls = 0;
    bit fin = 1'b0;
    bit rst_done = 1'b0;
    @(posedge clk); #1;
    arm = 1'b1;
    for (int cyc = 0; cyc < 1000 && !fin; cyc++) begin
      @(posedge clk); #1;
      arm = (kind == 4 && cyc == 20);
      reset = 1'b0;
      case (kind)
        1: begin sample_valid = (idx < 40); sample_in = 16'(idx + 1); end
        2: begin
          sample_valid = (cyc % 2 == 0) && (idx < 40);
          sample_in = sample_valid ? sine(idx) : 16'($urandom);
        end
        6: begin sample_valid = 1'b1; sample_in = 16'hFFFF; end
        default: begin sample_valid = ($urandom % 4) != 0; sample_in = 16'($urandom); end
      endcase
      if (sample_valid) idx++;
      if (kind == 3) begin
        if (mode[0] == 2 && rcnt[0] == 5 && stalls < 3 && rdv_w[0]) begin
          rd_ready = 1'b0; stalls++;
        end else rd_ready = 1'b1;
      end else if (kind == 4 || kind == 5 || kind == 7) rd_ready = ($urandom % 3) != 0;
      else rd_ready = 1'b1;
      if (kind == 5 && !rst_done && wcnt[0] == 12) begin reset = 1'b1; rst_done = 1'b1; end
      fin = (cyc > 0) && !reset && (mode[0] == 0) && (mode[1] == 0);
    end
    sample_valid = 1'b0;
    rd_ready = 1'b0;
    check_eq($sformatf("session_end_k%0d", kind), fin, 1'b1);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 2; k++) begin
      check_eq("rst_rd_data", rdd_w[k], 16'h0000);
      check_eq("rst_pmax", pmx_w[k], 16'h8000);
      check_eq("rst_pmin", pmn_w[k], 16'h7FFF);
    end
    reset = 1'b0;

    run(1);
    check_eq("ramp_pmax", pmx_w[0], 16'd40);
    check_eq("ramp_pmin", pmn_w[0], 16'd9);
    check_eq("ramp_pmax_s0", pmx_w[1], 16'd32);
    check_eq("ramp_pmin_s0", pmn_w[1], 16'd1);

    run(2);
    for (int k = 0; k < 2; k++) begin
      check_eq("sine_pmax", pmx_w[k], 16'h3FC0);
      check_eq("sine_pmin", pmn_w[k], 16'hC040);
    end

    run(3);
    run(4);
    run(5);
    for (int k = 0; k < 2; k++) begin
      check_eq("rst_mid_busy", busy_w[k], 1'b0);
      check_eq("rst_mid_rd_data", rdd_w[k], 16'h0000);
      check_eq("rst_mid_pmax", pmx_w[k], 16'h8000);
      check_eq("rst_mid_pmin", pmn_w[k], 16'h7FFF);
    end
    run(7);
    run(6);
    for (int k = 0; k < 2; k++) begin
      check_eq("neg1_pmax", pmx_w[k], 16'hFFFF);
      check_eq("neg1_pmin", pmn_w[k], 16'hFFFF);
    end

    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
